uart_rx_oversample: RTL and testbench
=====================================

// Module: uart_rx_oversample
// PURPOSE
//  16x-oversampling UART receiver for the APB UART peripheral.
//  Converts the serial rx pin into bytes, LSB first, 8N1 frames.
//  Sits between the rx pad and the RX FIFO:
//   - rx_done drives the FIFO push;
//   - rx_data drives the FIFO push_data;
//   - rx_busy feeds the UART status register.
//  Majority-votes each bit and flags framing errors without pushing bad bytes.
// PARAMETERS
//  DATA_BITS   8   data bits per frame (5..8); rx_data width
//  MID_TICK    8   centre sample tick; majority uses ticks MID_TICK-1, MID_TICK, MID_TICK+1
// PORTS
//  clk        in   1          system clock (PCLK domain); single clock
//  rst_n      in   1          asynchronous, active-low reset
//  b_16tick   in   1          1-clk strobe at 16x baud, from the baud tick generator
//  rx         in   1          asynchronous serial input, idle high
//  rx_data    out  DATA_BITS  last correctly framed byte
//  rx_done    out  1          1-clk pulse when rx_data is updated (FIFO push)
//  rx_busy    out  1          high while a frame is in progress
//  frame_err  out  1          1-clk pulse when the stop bit samples low
// BEHAVIOUR
//  Reset values: rx_data=0, rx_done=0, rx_busy=0, frame_err=0.
//   - rx sync flops and edge-history flop reset to 1; FSM resets to IDLE.
//  Reset is async. Asserting it mid-frame aborts the frame immediately.
//   - No rx_done or frame_err is emitted for the aborted frame.
//  Synchronizer:
//   - rx passes through 2 flops to give rx_s (2 clk latency).
//   - A third flop rx_q gives the previous value for edge detection.
//  Counters advance only on cycles with b_16tick=1:
//   - tick_cnt: 4-bit, 0..15;
//   - bit_cnt: 0..DATA_BITS-1.
//  Sampling: in every bit, rx_s is captured on ticks MID_TICK-1, MID_TICK and MID_TICK+1.
//   - bit value = majority (>=2 of 3); decided on tick MID_TICK+1.
//  FSM:
//   IDLE : rx_busy=0.
//          - Falling edge (rx_q=1 && rx_s=0) -> START; tick_cnt=0.
//          - A level-low rx without an edge never starts a frame (blocks re-trigger on break).
//   START: if start-bit majority=1 at tick MID_TICK+1 -> false start, go to IDLE silently.
//          - Otherwise at tick 15 -> DATA; tick_cnt=0, bit_cnt=0.
//   DATA : voted bit is shifted into the shift reg MSB side (LSB-first line order).
//          - At tick 15: if bit_cnt==DATA_BITS-1 -> STOP, else bit_cnt++.
//   STOP : decision at tick MID_TICK+1, then -> IDLE (early exit gives resync margin).
//          - vote=1: rx_data<=shift reg and rx_done=1 in the same clk; rx_data is valid while rx_done is high.
//          - vote=0: frame_err=1 for 1 clk; rx_data is unchanged; no rx_done.
//  rx_busy = (state != IDLE), registered.
//   - Rises 1 clk after the edge is seen in rx_s.
//   - Falls in the clk after the STOP or false-start decision.
//  rx_done and frame_err are mutually exclusive and never asserted for more than 1 clk.
//  A start edge arriving in the clk right after the STOP decision is accepted.
//  A falling edge seen outside IDLE is ignored.
//  b_16tick arriving on the same clk as a start edge: tick_cnt stays 0; counting begins with the next tick.
// TESTING
//  Setup: 100 MHz clk, b_16tick every 651 clk (9600 baud); 1 bit = 16 ticks.
//  1. Frame 0xA5, 8N1
//     -> one rx_done pulse, rx_data=0xA5, frame_err=0; rx_busy high throughout the frame.
//  2. rx low for 4 ticks, then high
//     -> no rx_done or frame_err; rx_busy returns to 0 by tick 9.
//  3. 0x3C sent with stop bit=0, after 0xA5
//     -> one frame_err pulse, no rx_done, rx_data stays 0xA5.
//  4. Break: rx held low for 30 bit times, then high, then 0x55
//     -> exactly one frame_err for the break; 0x55 received with rx_done.
//  5. 0x0F with sample tick 8 of bit 2 inverted (glitch)
//     -> rx_data=0x0F, no error.
//  6. rst_n pulsed low mid bit 4 of 0x81, then 0xFF sent after idle
//     -> all outputs 0 during reset, no pulse for 0x81; 0xFF received.

Source files
------------

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 16x oversampled 8N1 UART receiver.
// Majority-voted bits, framing error flag, no push on bad frames.
module uart_rx_oversample #(
   parameter int DATA_BITS = 8,
   parameter int MID_TICK  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 b_16tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done,
   output logic                 rx_busy,
   output logic                 frame_err
);

   localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [3:0] T_LO  = 4'(MID_TICK - 1);
   localparam logic [3:0] T_MID = 4'(MID_TICK);
   localparam logic [3:0] T_HI  = 4'(MID_TICK + 1);
   localparam logic [3:0] T_END = 4'd15;
   localparam logic [BCW-1:0] B_LAST = BCW'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t               state;
   logic                 rx_m;
   logic                 rx_s;
   logic                 rx_q;
   logic [3:0]           tick_cnt;
   logic [BCW-1:0]       bit_cnt;
   logic                 s_lo;
   logic                 s_mid;
   logic                 vote;
   logic                 fall;
   logic [DATA_BITS-1:0] shreg;

   // two-flop synchronizer plus history flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_q <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_q <= rx_s;
      end
   end

   // 2-of-3 vote: two stored samples plus the live third sample
   always_comb begin
      vote = 1'b0;
      fall = 1'b0;
      vote = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);
      fall = rx_q & ~rx_s;
   end

   // receive FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         s_lo      <= 1'b1;
         s_mid     <= 1'b1;
         shreg     <= '0;
         rx_data   <= '0;
         rx_done   <= 1'b0;
         rx_busy   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         if (state != IDLE && b_16tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == T_LO) begin
               s_lo <= rx_s;
            end
            if (tick_cnt == T_MID) begin
               s_mid <= rx_s;
            end
         end
         unique case (state)
            IDLE: begin
               if (fall) begin
                  state    <= START;
                  tick_cnt <= '0;
                  rx_busy  <= 1'b1;
               end
            end
            START: begin
               if (b_16tick) begin
                  if (tick_cnt == T_HI && vote) begin
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                  end else if (tick_cnt == T_END) begin
                     state    <= DATA;
                     tick_cnt <= '0;
                     bit_cnt  <= '0;
                  end
               end
            end
            DATA: begin
               if (b_16tick) begin
                  if (tick_cnt == T_HI) begin
                     shreg <= {vote, shreg[DATA_BITS-1:1]};
                  end
                  if (tick_cnt == T_END) begin
                     tick_cnt <= '0;
                     if (bit_cnt == B_LAST) begin
                        state <= STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
            end
            STOP: begin
               if (b_16tick && tick_cnt == T_HI) begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
                  if (vote) begin
                     rx_data <= shreg;
                     rx_done <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: directed bench for the UART receiver.
// Uses a shortened 16x tick period (every 4 clk) to keep runs short.
module tb_uart_rx_oversample;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       b_16tick = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rx_busy;
   logic       frame_err;

   int n_assert = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int div_cnt = 0;

   uart_rx_oversample dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .b_16tick  (b_16tick),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .rx_busy   (rx_busy),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   // tick strobe, changed on the falling edge
   always @(negedge clk) begin
      div_cnt = (div_cnt == 3) ? 0 : div_cnt + 1;
      b_16tick = (div_cnt == 0);
   end

   // pulse counters
   always @(negedge clk) begin
      if (rx_done) done_cnt++;
      if (frame_err) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_tick();
      do @(posedge clk); while (!b_16tick);
      #1;
   endtask

   task automatic line(input logic v, input int n);
      rx = v;
      repeat (n) wait_tick();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v,
                             input logic glitch);
      line(1'b0, 16);
      for (int i = 0; i < 8; i++) begin
         if (glitch && i == 2) begin
            line(d[i], 8);
            line(~d[i], 1);
            line(d[i], 7);
         end else if (i == 4) begin
            line(d[i], 8);
            check("busy_mid", 32'(rx_busy), 32'd1);
            line(d[i], 8);
         end else begin
            line(d[i], 16);
         end
      end
      line(stop_v, 16);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_data", 32'(rx_data), 32'h0);
      check("rst_done", 32'(rx_done), 32'd0);
      check("rst_busy", 32'(rx_busy), 32'd0);
      check("rst_ferr", 32'(frame_err), 32'd0);
      rst_n = 1'b1;
      line(1'b1, 8);

      // 1: good frame 0xA5
      send_frame(8'hA5, 1'b1, 1'b0);
      line(1'b1, 4);
      check("t1_done", 32'(done_cnt), 32'd1);
      check("t1_ferr", 32'(err_cnt), 32'd0);
      check("t1_data", 32'(rx_data), 32'hA5);
      check("t1_idle", 32'(rx_busy), 32'd0);

      // 2: short low pulse is a false start
      line(1'b0, 2);
      check("t2_busy_hi", 32'(rx_busy), 32'd1);
      line(1'b0, 2);
      line(1'b1, 8);
      check("t2_busy_lo", 32'(rx_busy), 32'd0);
      line(1'b1, 8);
      check("t2_done", 32'(done_cnt), 32'd1);
      check("t2_ferr", 32'(err_cnt), 32'd0);

      // 3: bad stop bit
      send_frame(8'h3C, 1'b0, 1'b0);
      line(1'b1, 16);
      check("t3_ferr", 32'(err_cnt), 32'd1);
      check("t3_done", 32'(done_cnt), 32'd1);
      check("t3_data", 32'(rx_data), 32'hA5);

      // 4: break then a good frame
      line(1'b0, 30 * 16);
      line(1'b1, 16);
      check("t4_brk_ferr", 32'(err_cnt), 32'd2);
      check("t4_brk_done", 32'(done_cnt), 32'd1);
      send_frame(8'h55, 1'b1, 1'b0);
      line(1'b1, 4);
      check("t4_done", 32'(done_cnt), 32'd2);
      check("t4_data", 32'(rx_data), 32'h55);
      check("t4_ferr", 32'(err_cnt), 32'd2);

      // 5: single-sample glitch out-voted
      send_frame(8'h0F, 1'b1, 1'b1);
      line(1'b1, 4);
      check("t5_data", 32'(rx_data), 32'h0F);
      check("t5_done", 32'(done_cnt), 32'd3);
      check("t5_ferr", 32'(err_cnt), 32'd2);

      // 6: reset mid bit 4 of 0x81
      line(1'b0, 16);
      line(1'b1, 16);
      line(1'b0, 16 * 3);
      line(1'b0, 8);
      rst_n = 1'b0;
      #1;
      check("t6_rst_data", 32'(rx_data), 32'h0);
      check("t6_rst_done", 32'(rx_done), 32'd0);
      check("t6_rst_busy", 32'(rx_busy), 32'd0);
      check("t6_rst_ferr", 32'(frame_err), 32'd0);
      rx = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      line(1'b1, 200);
      check("t6_abort_done", 32'(done_cnt), 32'd3);
      check("t6_abort_ferr", 32'(err_cnt), 32'd2);
      send_frame(8'hFF, 1'b1, 1'b0);
      line(1'b1, 4);
      check("t6_data", 32'(rx_data), 32'hFF);
      check("t6_done", 32'(done_cnt), 32'd4);
      check("t6_ferr", 32'(err_cnt), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
